// File: rtl/bitbalance_arbiter.sv
// bitbalance_arbiter: two-requester scheduler for one shared popcount engine.
// A granted requester streams FRAME_LEN bytes. Their total ones count,
// a balance flag and the owner ID are then offered on a result handshake.
// Optional build macro BB_FIXED_PRIO_EN: requester 0 wins every tie
// (fixed priority) instead of round-robin.
module bitbalance_arbiter #(
   parameter int FRAME_LEN = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   output logic       req1_ready,
   output logic       res_valid,
   input  logic       res_ready,
   output logic       res_id,
   output logic [7:0] res_ones,
   output logic       res_balanced
);

   // Beat index of the final byte in a frame. A frame is balanced when its
   // ones count equals half of its 8*FRAME_LEN bits.
   localparam logic [4:0] LAST_BEAT = 5'(FRAME_LEN - 1);
   localparam logic [7:0] HALF_BITS = 8'(4 * FRAME_LEN);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t       state;
   state_t       state_nxt;
   logic         owner;
   logic         last_grant;
   logic [7:0]   acc;
   logic [4:0]   beat_cnt;
   logic         grant_sel;
   logic         any_valid;
   logic         own_valid;
   logic [7:0]   own_data;
   logic [3:0]   own_ones;
   logic [7:0]   acc_sum;
   logic         beat_fire;
   logic         last_beat;

   function automatic logic [3:0] popcount8(input logic [7:0] d);
      logic [3:0] cnt;
      cnt = 4'd0;
      for (int i = 0; i < 8; i++) begin
         cnt = cnt + {3'b000, d[i]};
      end
      return cnt;
   endfunction

   assign any_valid = req0_valid | req1_valid;

`ifdef BB_FIXED_PRIO_EN
   // Requester 0 always wins; requester 1 is granted only when it is alone.
   assign grant_sel = ~req0_valid;
`else
   // On a tie the requester that did not own the previous frame wins.
   assign grant_sel = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
`endif

   // Owner-side data mux feeding the single popcount engine.
   assign own_valid = owner ? req1_valid : req0_valid;
   assign own_data  = owner ? req1_data  : req0_data;
   assign own_ones  = popcount8(own_data);
   assign acc_sum   = acc + {4'b0000, own_ones};
   assign beat_fire = (state == S_ACCUM) && own_valid;
   assign last_beat = (beat_cnt == LAST_BEAT);

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: grant, stream the frame, then hold until the result is taken.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (any_valid)              state_nxt = S_ACCUM;
         S_ACCUM: if (beat_fire && last_beat) state_nxt = S_DONE;
         S_DONE:  if (res_ready)              state_nxt = S_IDLE;
         default:                             state_nxt = S_IDLE;
      endcase
   end

   // Ready decode: only the owner is ready, and only while accumulating.
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (state == S_ACCUM) begin
         req0_ready = ~owner;
         req1_ready = owner;
      end
   end

   // Owner latch, ones accumulation and registered result outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         owner        <= 1'b0;
         last_grant   <= 1'b1;
         acc          <= 8'd0;
         beat_cnt     <= 5'd0;
         res_valid    <= 1'b0;
         res_id       <= 1'b0;
         res_ones     <= 8'd0;
         res_balanced <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (any_valid) begin
                  owner <= grant_sel;
               end
            end
            S_ACCUM: begin
               if (beat_fire) begin
                  acc      <= acc_sum;
                  beat_cnt <= beat_cnt + 5'd1;
                  if (last_beat) begin
                     res_valid    <= 1'b1;
                     res_id       <= owner;
                     res_ones     <= acc_sum;
                     res_balanced <= (acc_sum == HALF_BITS);
                  end
               end
            end
            S_DONE: begin
               if (res_ready) begin
                  res_valid  <= 1'b0;
                  last_grant <= owner;
                  acc        <= 8'd0;
                  beat_cnt   <= 5'd0;
               end
            end
            default: begin
               res_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bitbalance_arbiter.sv
// Testbench for bitbalance_arbiter. It compares the DUT against a frame-level
// model: round-robin (or fixed-priority) ownership plus per-frame ones totals.
module tb_bitbalance_arbiter;

   localparam int FRAME_LEN = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       req0_valid = 1'b0;
   logic [7:0] req0_data = 8'h00;
   logic       req0_ready;
   logic       req1_valid = 1'b0;
   logic [7:0] req1_data = 8'h00;
   logic       req1_ready;
   logic       res_valid;
   logic       res_ready = 1'b1;
   logic       res_id;
   logic [7:0] res_ones;
   logic       res_balanced;

   bitbalance_arbiter #(.FRAME_LEN(FRAME_LEN)) dut (
      .clk          (clk),
      .reset        (reset),
      .req0_valid   (req0_valid),
      .req0_data    (req0_data),
      .req0_ready   (req0_ready),
      .req1_valid   (req1_valid),
      .req1_data    (req1_data),
      .req1_ready   (req1_ready),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_id       (res_id),
      .res_ones     (res_ones),
      .res_balanced (res_balanced)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       id;
      logic [7:0] ones;
      logic       bal;
   } res_t;

   res_t       exp_q[$];
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic [7:0] a[$];
   logic [7:0] b[$];
   logic [7:0] e[$];
   int         n_asserts = 0;
   int         n_fail = 0;
   int         cyc = 0;
   int         first_rv = -1;
   int         gap0 = 0;
   int         acc0_cnt = 0;
   logic       gap_arm = 1'b0;
   logic       rr_hold = 1'b0;
   logic       rand_rr = 1'b0;
   logic       model_last = 1'b1;

   function automatic int ones8(input logic [7:0] v);
      int n;
      n = 0;
      for (int i = 0; i < 8; i++) n += int'(v[i]);
      return n;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_asserts++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Queue both requesters' bytes and plan the resulting frames from the arbitration rules.
   task automatic load(input logic [7:0] la[$], input logic [7:0] lb[$]);
      int   i0, i1, s;
      logic p0, p1, own;
      res_t r;
      i0 = 0;
      i1 = 0;
      foreach (la[k]) q0.push_back(la[k]);
      foreach (lb[k]) q1.push_back(lb[k]);
      while (i0 < la.size() || i1 < lb.size()) begin
         p0 = (i0 < la.size());
         p1 = (i1 < lb.size());
`ifdef BB_FIXED_PRIO_EN
         own = (p0 && p1) ? 1'b0 : p1;
`else
         own = (p0 && p1) ? ~model_last : p1;
`endif
         s = 0;
         for (int k = 0; k < FRAME_LEN; k++) s += own ? ones8(lb[i1 + k]) : ones8(la[i0 + k]);
         if (own) i1 += FRAME_LEN;
         else     i0 += FRAME_LEN;
         r.id   = own;
         r.ones = 8'(s);
         r.bal  = (2 * s == 8 * FRAME_LEN);
         exp_q.push_back(r);
         model_last = own;
      end
   endtask

   task automatic apply_reset();
      q0.delete();
      q1.delete();
      exp_q.delete();
      gap0 = 0;
      gap_arm = 1'b0;
      rr_hold = 1'b0;
      acc0_cnt = 0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      req0_data = 8'h00;
      req1_data = 8'h00;
      res_ready = 1'b1;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_res_valid", res_valid, 0);
      check("rst_res_id", res_id, 0);
      check("rst_res_ones", res_ones, 0);
      check("rst_res_bal", res_balanced, 0);
      check("rst_req0_ready", req0_ready, 0);
      check("rst_req1_ready", req1_ready, 0);
      reset = 1'b1;
      cyc = 0;
      first_rv = -1;
      model_last = 1'b1;
   endtask

   // One clock: drive, sample at the falling edge, retire handshakes at the rising edge.
   task automatic tick();
      logic a0, a1, rv, rr;
      if (rand_rr) rr_hold = ($urandom_range(0, 2) == 0);
      req0_valid = (q0.size() > 0) && (gap0 == 0);
      req0_data  = (q0.size() > 0) ? q0[0] : 8'h00;
      req1_valid = (q1.size() > 0);
      req1_data  = (q1.size() > 0) ? q1[0] : 8'h00;
      res_ready  = ~rr_hold;
      @(negedge clk);
      cyc++;
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      rv = res_valid;
      rr = res_ready;
      if (rv && first_rv < 0) first_rv = cyc;
      if (req0_ready || req1_ready) begin
         if (exp_q.size() == 0) check("grant_unexpected", {req1_ready, req0_ready}, 0);
         else check("grant_owner", {req1_ready, req0_ready}, exp_q[0].id ? 2 : 1);
      end
      if (rv && rr) begin
         if (exp_q.size() == 0) begin
            check("res_unexpected", res_valid, 0);
         end else begin
            check("res_id", res_id, exp_q[0].id);
            check("res_ones", res_ones, exp_q[0].ones);
            check("res_balanced", res_balanced, exp_q[0].bal);
            exp_q.delete(0);
         end
      end
      @(posedge clk);
      if (a0) begin
         q0.delete(0);
         acc0_cnt++;
      end
      if (a1) q1.delete(0);
      if (gap0 > 0) gap0--;
      if (gap_arm && acc0_cnt == 2) begin
         gap0 = 3;
         gap_arm = 1'b0;
      end
      #1;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         tick();
         n++;
      end
      check("drain_timeout", exp_q.size(), 0);
   endtask

   task automatic rand_bytes(output logic [7:0] q[$], input int nbytes);
      q.delete();
      for (int k = 0; k < nbytes; k++) q.push_back(8'($urandom));
   endtask

   initial begin
      int n;
      e.delete();

      // Single req0 frame, first result on cycle 6 after release.
      apply_reset();
      a = '{8'hFF, 8'h00, 8'h0F, 8'hF0};
      load(a, e);
      drain(40);
      check("single_latency", first_rv, 6);

      // Tie from reset with both requesters streaming two frames each.
      apply_reset();
      rand_bytes(a, 2 * FRAME_LEN);
      rand_bytes(b, 2 * FRAME_LEN);
      load(a, b);
      drain(80);

      // Owner drops valid for three cycles after two accepted bytes.
      apply_reset();
      a = '{8'h01, 8'h01, 8'h01, 8'h01};
      gap_arm = 1'b1;
      load(a, e);
      drain(60);
      check("gap_latency", first_rv, 9);

      // Result backpressure with requester 1 waiting behind it.
      apply_reset();
      rand_bytes(a, FRAME_LEN);
      load(a, e);
      rr_hold = 1'b1;
      n = 0;
      while (first_rv < 0 && n < 20) begin
         tick();
         n++;
      end
      check("bp_result_seen", res_valid, 1);
      rand_bytes(b, FRAME_LEN);
      load(e, b);
      for (int k = 0; k < 5; k++) begin
         tick();
         check("bp_valid", res_valid, 1);
         check("bp_id", res_id, exp_q[0].id);
         check("bp_ones", res_ones, exp_q[0].ones);
         check("bp_readies", {req1_ready, req0_ready}, 0);
      end
      rr_hold = 1'b0;
      tick();
      check("bp_idle_valid", res_valid, 0);
      check("bp_idle_readies", {req1_ready, req0_ready}, 0);
      drain(40);

      // Reset after two accepted bytes discards the partial frame.
      apply_reset();
      rand_bytes(a, FRAME_LEN);
      load(a, e);
      n = 0;
      while (acc0_cnt < 2 && n < 20) begin
         tick();
         n++;
      end
      check("abort_two_beats", acc0_cnt, 2);
      apply_reset();
      for (int k = 0; k < 4; k++) begin
         tick();
         check("abort_no_result", res_valid, 0);
      end
      a = '{8'hAA, 8'hAA, 8'hAA, 8'hAA};
      load(a, e);
      drain(40);

      // Extremes on requester 1 alone: zero ones and all ones.
      b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      load(e, b);
      drain(40);

      // Random frame mixes with random result backpressure.
      rand_rr = 1'b1;
      for (int r = 0; r < 4; r++) begin
         rand_bytes(a, FRAME_LEN * $urandom_range(0, 3));
         rand_bytes(b, FRAME_LEN * $urandom_range(1, 3));
         load(a, b);
         drain(400);
      end
      rand_rr = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

// File: doc/bitbalance_arbiter.md
# bitbalance_arbiter

Two-requester scheduler for the shared popcount datapath. It grants one requester at a time exclusive use of the ones-counting engine for a fixed-length frame of bytes, and accumulates the ones count across the frame. It then presents the frame total, a balance flag and the owner ID on a result handshake. It sits between the byte sources and downstream balance-checking logic, so the team keeps a single popcount instance.

## Interface
- FRAME_LEN, 4: bytes per frame; legal range 1..31, so the total fits 8 bits.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset; all state clears on a clk edge while reset==0.
- req0_valid  input  1  requester 0 byte valid.
- req0_data  input  8  requester 0 byte.
- req0_ready  output  1  requester 0 byte accepted when valid&ready.
- req1_valid  input  1  requester 1 byte valid.
- req1_data  input  8  requester 1 byte.
- req1_ready  output  1  requester 1 byte accepted when valid&ready.
- res_valid  output  1  result available.
- res_ready  input  1  downstream accepts result.
- res_id  output  1  requester that owned the frame.
- res_ones  output  8  total ones in the frame.
- res_balanced  output  1  1 when 2*res_ones == 8*FRAME_LEN.

## Operation
- States:
  - IDLE: no requester is granted.
    - If any reqN_valid is high, latch the owner and go to ACCUM.
    - No byte is accepted in IDLE.
  - ACCUM: owner's ready = 1 and the other requester's ready = 0.
    - Each accepted beat: acc += popcount(data) and beat_cnt += 1.
    - On the beat where beat_cnt == FRAME_LEN-1, go to DONE.
  - DONE: res_valid = 1; res_ones/res_id/res_balanced are held stable.
    - On res_ready, set last_grant = owner, clear acc and beat_cnt, and go to IDLE.
- Arbitration (round-robin):
  - Both valid: grant !last_grant.
  - One valid: grant that requester.
  - The grant is locked for the whole frame; the other requester's valid is ignored until the frame ends.
- popcount is purely combinational on the owner's data mux; acc is 8 bits and cannot overflow within the legal FRAME_LEN range.
- Owner valid low in ACCUM: the block stalls indefinitely and holds acc and beat_cnt; there is no timeout.
- Data stability: requesters must hold data while valid && !ready; the block samples only on accepted beats.
- Reset values:
  - State = IDLE; last_grant = 1, so requester 0 wins the first tie.
  - acc, beat_cnt, owner = 0.
  - All readies = 0, res_valid = 0, res_id = 0, res_ones = 0, res_balanced = 0.
- Reset mid-frame or mid-DONE: the partial frame and any pending result are discarded with no output. The aborted requester must restart its frame from byte 0.

## Timing
- Grant latency: one IDLE cycle after valid is seen; readiness rises on the following cycle.
- Accept rate: one byte per cycle in ACCUM when the owner keeps valid high.
- res_valid rises the cycle after the last beat is accepted.
- Minimum frame period: FRAME_LEN+2 cycles (IDLE + FRAME_LEN beats + DONE, with res_ready=1).
- res_ready low: the block stays in DONE and both requester readies stay 0 (backpressure).
- All outputs are registered except reqN_ready, which decode directly from state and owner.

## Configuration
- BB_FIXED_PRIO_EN:
  - Defined: fixed priority; requester 0 wins every tie and last_grant is unused.
  - Undefined (default): round-robin as above.
- Interface and timing are identical in both builds.

## Test plan
- Single frame, req0 only, FRAME_LEN=4, bytes 0xFF,0x00,0x0F,0xF0: res_valid on cycle 6 after reset release, res_id=0, res_ones=16, res_balanced=1.
- Tie after reset, both valid continuously: frame order 0,1,0,1; req1_ready stays 0 throughout req0's frame.
- Same tie with BB_FIXED_PRIO_EN and both valid: every frame is res_id=0; req1 never gets ready.
- Owner valid gaps: req0 deasserts for 3 cycles after byte 2. Stall only; bytes 0x01×4 give res_ones=4 and res_balanced=0.
- Backpressure: res_ready=0 for 5 cycles. res_valid and the held result stay stable, reqN_ready stay 0, and IDLE follows the res_ready cycle.
- Reset asserted after 2 accepted bytes: no res_valid. A new 4-byte frame of 0xAA gives res_ones=16 (stale bytes excluded).
